// File: rtl/tft_init_pkg.sv
// tft_init_pkg
// Shared definitions for the TFT init sequencer: FSM state encoding, the
// ROM address window that is issued, the panel power-on delay points and
// a helper that converts a clock frequency into cycles per millisecond.
package tft_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEND   = 3'd2,
        ST_DELAY  = 3'd3,
        ST_STREAM = 3'd4
    } state_t;

    localparam logic [6:0] INIT_FIRST_ADDR = 7'd1;
    localparam logic [6:0] INIT_LAST_ADDR  = 7'd89;

    // Delay points: the wait follows the handshake of the listed address.
    localparam logic [6:0] DLY_ADDR_0 = 7'd10;
    localparam logic [6:0] DLY_ADDR_1 = 7'd20;
    localparam logic [6:0] DLY_ADDR_2 = 7'd22;
    localparam logic [6:0] DLY_ADDR_3 = 7'd86;
    localparam logic [7:0] DLY_MS_0   = 8'd40;
    localparam logic [7:0] DLY_MS_1   = 8'd10;
    localparam logic [7:0] DLY_MS_2   = 8'd50;
    localparam logic [7:0] DLY_MS_3   = 8'd50;

    // Milliseconds to wait after the given address; 0 means no delay point.
    function automatic logic [7:0] delay_ms(input logic [6:0] addr);
        logic [7:0] ms;
        case (addr)
            DLY_ADDR_0: ms = DLY_MS_0;
            DLY_ADDR_1: ms = DLY_MS_1;
            DLY_ADDR_2: ms = DLY_MS_2;
            DLY_ADDR_3: ms = DLY_MS_3;
            default:    ms = 8'd0;
        endcase
        return ms;
    endfunction

    // Clock cycles in one millisecond.
    function automatic int unsigned MS_CYCLES(input int unsigned freq);
        return freq / 32'd1000;
    endfunction

endpackage

// File: rtl/tft_delay_timer.sv
// tft_delay_timer
// Loadable millisecond down-counter. A 32-bit prescaler counts MS_CYC clock
// cycles per millisecond; the ms counter counts milliseconds. After a load
// with ms = M, `expired` is high in exactly the M*MS_CYC-th following cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous clear (sequence restart)
//   load, ms      start a new delay of `ms` milliseconds
//   expired       one-cycle pulse in the last cycle of the delay
module tft_delay_timer
    import tft_init_pkg::*;
#(
    parameter int unsigned MS_CYC = 32'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] ms,
    output logic       expired
);

    localparam logic [31:0] PRE_RELOAD = 32'(MS_CYC - 32'd1);

    logic [31:0] pre_cnt_r;
    logic [7:0]  ms_cnt_r;

    // Prescaler and millisecond counters; idle while ms_cnt_r is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r <= 32'd0;
            ms_cnt_r  <= 8'd0;
        end else if (clr) begin
            pre_cnt_r <= 32'd0;
            ms_cnt_r  <= 8'd0;
        end else if (load) begin
            pre_cnt_r <= PRE_RELOAD;
            ms_cnt_r  <= ms;
        end else if (ms_cnt_r != 8'd0) begin
            if (pre_cnt_r == 32'd0) begin
                pre_cnt_r <= PRE_RELOAD;
                ms_cnt_r  <= ms_cnt_r - 8'd1;
            end else begin
                pre_cnt_r <= pre_cnt_r - 32'd1;
            end
        end
    end

    // Last cycle of the last millisecond.
    always_comb begin
        expired = (ms_cnt_r == 8'd1) && (pre_cnt_r == 32'd0);
    end

endmodule

// File: rtl/tft_init_sequencer.sv
// tft_init_sequencer
// Walks init ROM addresses 1..89, issuing each 17-bit word as an RS-tagged
// 16-bit transfer to the TFT SPI transmitter, then hands the transmitter to
// the pixel stream. Build macro TFT_INIT_DELAY_EN enables the panel
// power-on millisecond delays; without it delay points advance directly.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         pulse: begin / restart the sequence
//   rom_addr, rom_data            combinational init ROM interface
//   tx_valid, tx_ready,
//   tx_data, tx_rs                transfer interface to the SPI transmitter
//   pix_valid, pix_ready, pix_data  pixel stream (owns tx after init)
//   busy, init_done               sequence status
module tft_init_sequencer
    import tft_init_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [6:0]  rom_addr,
    input  logic [16:0] rom_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_rs,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        busy,
    output logic        init_done
);

    localparam int unsigned MS_CYC = MS_CYCLES(CLK_FREQ_HZ);

    state_t      state_r;
    state_t      state_s;
    logic [6:0]  rom_addr_r;
    logic [15:0] tx_data_r;
    logic        tx_rs_r;

    logic        addr_set_s;
    logic        addr_inc_s;
    logic        capture_s;
    logic        timer_load_s;
    logic        timer_clr_s;
    logic        timer_expired_s;
    logic [7:0]  cur_ms_s;

    assign cur_ms_s = delay_ms(rom_addr_r);

    tft_delay_timer #(
        .MS_CYC (MS_CYC)
    ) u_delay_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .load    (timer_load_s),
        .ms      (cur_ms_s),
        .expired (timer_expired_s)
    );

    // Next-state and control decode.
    always_comb begin
        state_s      = state_r;
        addr_set_s   = 1'b0;
        addr_inc_s   = 1'b0;
        capture_s    = 1'b0;
        timer_load_s = 1'b0;
        timer_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_LOAD;
                    addr_set_s  = 1'b1;
                    timer_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                capture_s = 1'b1;
                state_s   = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
`ifdef TFT_INIT_DELAY_EN
                    if (cur_ms_s != 8'd0) begin
                        state_s      = ST_DELAY;
                        timer_load_s = 1'b1;
                    end else if (rom_addr_r == INIT_LAST_ADDR) begin
                        state_s = ST_STREAM;
                    end else begin
                        state_s    = ST_LOAD;
                        addr_inc_s = 1'b1;
                    end
`else
                    if (rom_addr_r == INIT_LAST_ADDR) begin
                        state_s = ST_STREAM;
                    end else begin
                        state_s    = ST_LOAD;
                        addr_inc_s = 1'b1;
                    end
`endif
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DELAY: begin
                if (timer_expired_s) begin
                    state_s    = ST_LOAD;
                    addr_inc_s = 1'b1;
                end else begin
                    state_s = ST_DELAY;
                end
            end
            ST_STREAM: begin
                // Restart; a pixel handshake this cycle is unaffected.
                if (start) begin
                    state_s     = ST_LOAD;
                    addr_set_s  = 1'b1;
                    timer_clr_s = 1'b1;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, ROM address and captured word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rom_addr_r <= 7'd0;
            tx_data_r  <= 16'd0;
            tx_rs_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (addr_set_s) begin
                rom_addr_r <= INIT_FIRST_ADDR;
            end else if (addr_inc_s) begin
                rom_addr_r <= rom_addr_r + 7'd1;
            end
            if (capture_s) begin
                tx_data_r <= rom_data[15:0];
                tx_rs_r   <= rom_data[16];
            end
        end
    end

    // Output mux: the pixel stream drives the transmitter once init is done.
    always_comb begin
        rom_addr  = rom_addr_r;
        busy      = (state_r == ST_LOAD) || (state_r == ST_SEND) || (state_r == ST_DELAY);
        init_done = (state_r == ST_STREAM);
        if (state_r == ST_STREAM) begin
            tx_valid  = pix_valid;
            tx_data   = pix_data;
            tx_rs     = 1'b1;
            pix_ready = tx_ready;
        end else begin
            tx_valid  = (state_r == ST_SEND);
            tx_data   = tx_data_r;
            tx_rs     = tx_rs_r;
            pix_ready = 1'b0;
        end
    end

endmodule

// File: doc/tft_init_sequencer.md
# tft_init_sequencer

Sequencer that drives the TFT controller's 91-entry initialization register ROM and feeds its words to the TFT SPI transmitter. After reset and a `start` pulse, it walks ROM addresses 1..89 and issues each 17-bit word as an RS-tagged 16-bit transfer. It inserts the panel's power-on millisecond delays at fixed points. When the final GRAM-write command (address 89) has been sent, it hands the transmitter to the pixel stream.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency; one millisecond = `CLK_FREQ_HZ/1000` cycles (must be ≥ 1).
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins (or restarts) the init sequence.
- `rom_addr` out 7: address to the init ROM (combinational ROM).
- `rom_data` in 17: ROM word; bit 16 = RS, bits 15:0 = payload.
- `tx_valid` out 1: transfer request to the SPI transmitter.
- `tx_ready` in 1: transmitter accepts a word when `tx_valid && tx_ready`.
- `tx_data` out 16: word to transmit.
- `tx_rs` out 1: RS line for the word (0 = index/command, 1 = data).
- `pix_valid` in 1 / `pix_ready` out 1 / `pix_data` in 16: pixel stream, active only after init.
- `busy` out 1: init sequence in progress.
- `init_done` out 1: sequence complete; pixel stream owns the transmitter.

## Operation
- States: IDLE, LOAD, SEND, DELAY, STREAM.
- IDLE: outputs quiescent. `start` → LOAD with `rom_addr`=1. Address 0 (dummy word) is never issued.
- LOAD (1 cycle): capture `rom_data[15:0]`→`tx_data` and `rom_data[16]`→`tx_rs`. Next state is SEND.
- SEND: `tx_valid`=1 with `tx_data` and `tx_rs` held stable until handshake. On handshake:
  - If `rom_addr` is a delay point, go to DELAY.
  - Else if `rom_addr`=89, go to STREAM.
  - Else increment `rom_addr` and go to LOAD.
- Delay points (after handshake of that address): 10→40 ms, 20→10 ms, 22→50 ms, 86→50 ms.
- DELAY: `tx_valid`=0 for exactly ms×`CLK_FREQ_HZ/1000` cycles. Then `rom_addr`+1 and go to LOAD.
- STREAM: `init_done`=1, `busy`=0.
  - `tx_valid`=`pix_valid`, `tx_data`=`pix_data`, `tx_rs`=1 (combinational mux).
  - `pix_ready`=`tx_ready`. Outside STREAM, `pix_ready`=0.
- `busy`=1 in LOAD, SEND and DELAY.
- `start` while busy is ignored.
- `start` in STREAM restarts the sequence:
  - Next state LOAD, `rom_addr`=1, `init_done`=0.
  - A pixel handshake in that same cycle still completes.
- `rst` at any point: all state returns to IDLE immediately. A partially issued word is abandoned and `tx_valid` drops asynchronously.

## Timing
- Reset values: `rom_addr`=0, `tx_valid`=0, `tx_data`=0, `tx_rs`=0, `pix_ready`=0, `busy`=0, `init_done`=0.
- `start` high in cycle N → LOAD in N+1 → `tx_valid`=1 in N+2.
- Minimum 2 cycles per word when `tx_ready` is constantly 1, so the last word (addr 89) is accepted 2×89 cycles after start, plus delays.
- `init_done` rises the cycle after the addr-89 handshake.
- Data stability: once `tx_valid` rises, `tx_data` and `tx_rs` are unchanged until the handshake cycle.
- Delay counter is a 32-bit down-counter loaded in the handshake cycle. It is cleared on reset and restart.

## Configuration
- `TFT_INIT_DELAY_EN` defined: delays are inserted as specified.
- Not defined: the DELAY state is never entered. Delay points advance directly to the next LOAD, for fast simulation; the word sequence is otherwise identical.

## Structure
- Package `tft_init_pkg` holds:
  - State enum.
  - `INIT_FIRST_ADDR`=1 and `INIT_LAST_ADDR`=89.
  - Delay-point addresses and their millisecond values.
  - `MS_CYCLES(freq)` helper function.
- Sub-module `tft_delay_timer`: loadable ms down-counter with prescaler. Inputs are `load` and `ms[7:0]`; output is `expired`.

## Test plan
- Full sequence, `tx_ready`=1, `CLK_FREQ_HZ`=100_000, macro on → 89 transfers in order.
  - First transfer is RS=0 / 0x0010. Addr 24 transfer is RS=1 / 0x011C. Last transfer is RS=0 / 0x0022.
  - Gaps of 4000, 1000, 5000 and 5000 cycles appear after addrs 10, 20, 22 and 86.
- Random `tx_ready` back-pressure → `tx_data`/`tx_rs` stable while stalled; no word skipped or duplicated versus a ROM model.
- Macro off → no gaps; `init_done` rises exactly 179 cycles after `start` with `tx_ready`=1.
- STREAM: `pix_valid`=1, `pix_data`=0xF800, `tx_ready` toggling → `tx_rs`=1 and `tx_data`=0xF800; `pix_ready` mirrors `tx_ready`. Before `init_done`, `pix_ready`=0.
- `rst` asserted mid-DELAY after addr 20 → all outputs take reset values immediately. A later `start` reissues from addr 1.
- `start` during SEND → ignored. `start` in STREAM → `init_done`=0 next cycle and the sequence reissues from addr 1.
